// File: rtl/spi_rx_assembler_if.sv
// Sample handshake bundle between the SPI receive assembler and its consumer.
// The master side produces sample_data/sample_valid and the slave side answers with sample_ready.
interface spi_rx_assembler_if #(
  parameter int NUM_BYTES = 3
);

  logic [8*NUM_BYTES-1:0] sample_data;
  logic                   sample_valid;
  logic                   sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/spi_rx_assembler.sv
// Receive side of the SPI accelerometer master. It shifts MISO in MSB-first,
// emits each completed byte, and packs NUM_BYTES bytes into one sample word.
// The sample word is held in an output register that uses a valid/ready
// handshake with a sticky overrun flag. Frames cut short raise a one-cycle frame_err.
module spi_rx_assembler #(
  parameter int NUM_BYTES = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miso_i,
  input  logic                      cs_i,
  input  logic                      receive_i,
  input  logic                      clear_overrun_i,
  output logic [7:0]                byte_data_o,
  output logic                      byte_valid_o,
  output logic                      overrun_o,
  output logic                      frame_err_o,
  spi_rx_assembler_if.master        smp
);

  localparam int W    = 8 * NUM_BYTES;
  localparam int IDXW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BYTES - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [IDXW-1:0] byte_idx_q, byte_idx_d;
  logic [6:0]      shift_q, shift_d;
  logic [W-1:0]    asm_q, asm_d;
  logic [7:0]      byte_data_q, byte_data_d;
  logic            byte_valid_q, byte_valid_d;
  logic [W-1:0]    sample_data_q, sample_data_d;
  logic            sample_valid_q, sample_valid_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;

  logic            en;
  logic [7:0]      byte_new;
  logic            sample_load;
  logic            overrun_set;

  assign en       = receive_i && !cs_i;
  assign byte_new = {shift_q, miso_i};

  // Register every piece of state; reset clears everything immediately without raising frame_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      byte_idx_q     <= '0;
      shift_q        <= '0;
      asm_q          <= '0;
      byte_data_q    <= '0;
      byte_valid_q   <= 1'b0;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_idx_q     <= byte_idx_d;
      shift_q        <= shift_d;
      asm_q          <= asm_d;
      byte_data_q    <= byte_data_d;
      byte_valid_q   <= byte_valid_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      frame_err_q    <= frame_err_d;
    end
  end

  // Next-state logic: deserialise, complete bytes and frames, handle aborts, and manage the output handshake.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    byte_idx_d     = byte_idx_q;
    shift_d        = shift_q;
    asm_d          = asm_q;
    byte_data_d    = byte_data_q;
    byte_valid_d   = 1'b0;
    sample_data_d  = sample_data_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q;
    frame_err_d    = 1'b0;
    sample_load    = 1'b0;
    overrun_set    = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = SHIFT;
          shift_d   = byte_new[6:0];
          bit_cnt_d = 3'd1;
        end
      end
      SHIFT: begin
        if (en) begin
          shift_d   = byte_new[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_data_d  = byte_new;
            byte_valid_d = 1'b1;
            for (int i = 0; i < NUM_BYTES; i++) begin
              if (int'(byte_idx_q) == i) begin
                asm_d[8*(NUM_BYTES-i)-1 -: 8] = byte_new;
              end
            end
            if (byte_idx_q == LAST_IDX) begin
              byte_idx_d  = '0;
              sample_load = 1'b1;
            end else begin
              byte_idx_d = byte_idx_q + IDXW'(1);
            end
          end
        end else begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          byte_idx_d  = '0;
          frame_err_d = (bit_cnt_q != 3'd0) || (byte_idx_q != '0);
        end
      end
      default: begin
        state_d    = IDLE;
        bit_cnt_d  = '0;
        byte_idx_d = '0;
      end
    endcase

    if (sample_load) begin
      if (!sample_valid_q || smp.sample_ready) begin
        sample_data_d  = asm_d;
        sample_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (sample_valid_q && smp.sample_ready) begin
      sample_valid_d = 1'b0;
    end

    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (clear_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  assign byte_data_o      = byte_data_q;
  assign byte_valid_o     = byte_valid_q;
  assign overrun_o        = overrun_q;
  assign frame_err_o      = frame_err_q;
  assign smp.sample_data  = sample_data_q;
  assign smp.sample_valid = sample_valid_q;

endmodule

// File: tb/tb_spi_rx_assembler.sv
// Self-checking bench for spi_rx_assembler. A bit-queue reference model
// predicts byte, sample, overrun and frame_err behaviour from the serial
// stream. A second instance with NUM_BYTES = 2 covers the narrower word.
module tb_spi_rx_assembler;

  localparam int NB = 3;

  logic clk;
  logic rst;
  logic miso, cs, receive, clear_overrun;
  logic [7:0] byte_data;
  logic byte_valid, overrun, frame_err;

  logic miso2, cs2, receive2, clr2;
  logic [7:0] bd2;
  logic bv2, ov2, fe2;

  int checks;
  int failures;

  logic       mq[$];
  logic [7:0] m_bd;
  logic       m_bv, m_sv, m_ov, m_fe;
  logic [23:0] m_sd;

  spi_rx_assembler_if #(.NUM_BYTES(NB)) sif ();
  spi_rx_assembler_if #(.NUM_BYTES(2))  sif2 ();

  spi_rx_assembler #(.NUM_BYTES(NB)) dut (
    .clk             (clk),
    .rst             (rst),
    .miso_i          (miso),
    .cs_i            (cs),
    .receive_i       (receive),
    .clear_overrun_i (clear_overrun),
    .byte_data_o     (byte_data),
    .byte_valid_o    (byte_valid),
    .overrun_o       (overrun),
    .frame_err_o     (frame_err),
    .smp             (sif.master)
  );

  spi_rx_assembler #(.NUM_BYTES(2)) dut2 (
    .clk             (clk),
    .rst             (rst),
    .miso_i          (miso2),
    .cs_i            (cs2),
    .receive_i       (receive2),
    .clear_overrun_i (clr2),
    .byte_data_o     (bd2),
    .byte_valid_o    (bv2),
    .overrun_o       (ov2),
    .frame_err_o     (fe2),
    .smp             (sif2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] obs_vec();
    return {byte_valid, byte_data, sif.sample_valid, sif.sample_data, overrun, frame_err};
  endfunction

  function automatic logic [35:0] exp_vec();
    return {m_bv, m_bd, m_sv, m_sd, m_ov, m_fe};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_bd = '0; m_bv = 1'b0; m_sv = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_sd = '0;
  endtask

  // Reference behaviour for one clock edge, expressed over the queue of bits received in the current frame.
  task automatic model_edge(input logic en, input logic b, input logic ready, input logic clr);
    logic [23:0] word;
    logic [7:0]  b8;
    logic offer, ovset;
    offer = 1'b0; ovset = 1'b0; word = '0; b8 = '0;
    m_bv = 1'b0; m_fe = 1'b0;
    if (en) begin
      mq.push_back(b);
      if (mq.size() % 8 == 0) begin
        for (int i = mq.size() - 8; i < mq.size(); i++) b8 = {b8[6:0], mq[i]};
        m_bd = b8;
        m_bv = 1'b1;
      end
      if (mq.size() == 8 * NB) begin
        foreach (mq[i]) word = {word[22:0], mq[i]};
        mq.delete();
        offer = 1'b1;
      end
    end else if (mq.size() != 0) begin
      m_fe = 1'b1;
      mq.delete();
    end
    if (offer) begin
      if (!m_sv || ready) begin
        m_sd = word;
        m_sv = 1'b1;
      end else begin
        ovset = 1'b1;
      end
    end else if (m_sv && ready) begin
      m_sv = 1'b0;
    end
    if (ovset) m_ov = 1'b1;
    else if (clr) m_ov = 1'b0;
  endtask

  task automatic cycle(input logic r, input logic c, input logic b, input logic rdy, input logic clr);
    receive = r; cs = c; miso = b; sif.sample_ready = rdy; clear_overrun = clr;
    model_edge(r && !c, b, rdy, clr);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("[TB] FAIL reset_held got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
    if ({bv2, bd2, sif2.sample_valid, sif2.sample_data, ov2, fe2} !== 28'h0) begin
      failures++; $display("[TB] FAIL reset_dut2 got=%h want=0", {bv2, bd2, sif2.sample_valid, sif2.sample_data, ov2, fe2});
    end
    rst = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("[TB] FAIL reset_release got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_basic_frame();
    logic [23:0] w;
    int nbv, nsv;
    w = 24'h123456; nbv = 0; nsv = 0;
    for (int k = 0; k < 26; k++) begin
      if (k < 24) cycle(1'b1, 1'b0, w[23-k], 1'b1, 1'b0);
      else        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("[TB] FAIL basic_cycle%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (byte_valid) nbv++;
      if (sif.sample_valid) nsv++;
      if (k == 23) begin
        checks++;
        if (sif.sample_data !== 24'h123456) begin
          failures++; $display("[TB] FAIL basic_sample got=%h want=123456", sif.sample_data);
        end
      end
    end
    checks++;
    if (nbv != 3) begin
      failures++; $display("[TB] FAIL basic_byte_pulses got=%0d want=3", nbv);
    end
    checks++;
    if (nsv != 1) begin
      failures++; $display("[TB] FAIL basic_valid_cycles got=%0d want=1", nsv);
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] ws;
    ws = 48'hA1B2C3_010203;
    for (int k = 0; k < 48; k++) begin
      cycle(1'b1, 1'b0, ws[47-k], 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("[TB] FAIL bp_cycle%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({sif.sample_valid, sif.sample_data, overrun} !== {1'b1, 24'hA1B2C3, 1'b1}) begin
      failures++; $display("[TB] FAIL bp_hold got=%h want=%h", {sif.sample_valid, sif.sample_data, overrun}, {1'b1, 24'hA1B2C3, 1'b1});
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (sif.sample_valid !== 1'b0 || overrun !== 1'b1) begin
      failures++; $display("[TB] FAIL bp_accept got=%b%b want=01", sif.sample_valid, overrun);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_vec() !== exp_vec() || overrun !== 1'b0) begin
      failures++; $display("[TB] FAIL bp_clear got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    logic [47:0] ws;
    ws = {24'($urandom), 24'h0F0E0D};
    for (int k = 0; k < 48; k++) begin
      cycle(1'b1, 1'b0, ws[47-k], (k == 47), 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("[TB] FAIL simul_cycle%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({sif.sample_valid, sif.sample_data, overrun} !== {1'b1, 24'h0F0E0D, 1'b0}) begin
      failures++; $display("[TB] FAIL simul_load got=%h want=%h", {sif.sample_valid, sif.sample_data, overrun}, {1'b1, 24'h0F0E0D, 1'b0});
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("[TB] FAIL simul_drain got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_abort();
    logic [23:0] w;
    int nfe, nsv;
    w = 24'($urandom); nfe = 0; nsv = 0;
    for (int k = 0; k < 15; k++) begin
      if (k < 13)       cycle(1'b1, 1'b0, w[23-k], 1'b1, 1'b0);
      else if (k == 13) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      else              cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("[TB] FAIL abort_cycle%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (frame_err) nfe++;
      if (sif.sample_valid) nsv++;
    end
    checks++;
    if (nfe != 1 || nsv != 0) begin
      failures++; $display("[TB] FAIL abort_pulses got=fe%0d/sv%0d want=fe1/sv0", nfe, nsv);
    end
    w = 24'h778899;
    for (int k = 0; k < 25; k++) begin
      if (k < 24) cycle(1'b1, 1'b0, w[23-k], 1'b1, 1'b0);
      else        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("[TB] FAIL abort_next%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      if (k == 23) begin
        checks++;
        if (sif.sample_data !== 24'h778899) begin
          failures++; $display("[TB] FAIL abort_next_sample got=%h want=778899", sif.sample_data);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] w;
    w = 24'($urandom);
    for (int k = 0; k < 34; k++) begin
      if (k == 24) w = 24'($urandom);
      cycle(1'b1, 1'b0, w[23-(k%24)], 1'b0, 1'b0);
    end
    checks++;
    if (obs_vec() !== exp_vec() || sif.sample_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL arst_before got=%h want=%h", obs_vec(), exp_vec());
    end
    receive = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== 36'h0) begin
      failures++; $display("[TB] FAIL arst_clear got=%h want=0", obs_vec());
    end
    #1 rst = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    w = 24'($urandom);
    for (int k = 0; k < 25; k++) begin
      if (k < 24) cycle(1'b1, 1'b0, w[23-k], 1'b1, 1'b0);
      else        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("[TB] FAIL arst_next%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random_frames();
    logic [23:0] w;
    logic abort_f;
    int nb, gap;
    for (int f = 0; f < 12; f++) begin
      w = 24'($urandom);
      abort_f = ($urandom % 3 == 0);
      nb = abort_f ? $urandom_range(1, 23) : 24;
      gap = abort_f ? 1 : $urandom_range(0, 2);
      for (int k = 0; k < nb; k++) begin
        cycle(1'b1, 1'b0, w[23-k], 1'($urandom % 2), ($urandom % 6 == 0));
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++; $display("[TB] FAIL rand_f%0d_b%0d got=%h want=%h", f, k, obs_vec(), exp_vec());
        end
      end
      for (int g = 0; g < gap; g++) begin
        if ($urandom % 2 == 0) cycle(1'b1, 1'b1, 1'($urandom), 1'($urandom % 2), ($urandom % 6 == 0));
        else                   cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom % 2), ($urandom % 6 == 0));
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++; $display("[TB] FAIL rand_f%0d_gap%0d got=%h want=%h", f, g, obs_vec(), exp_vec());
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("[TB] FAIL rand_drain%0d got=%h want=%h", g, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_param_two_bytes();
    logic [15:0] w2;
    logic [7:0]  ebd;
    logic        ebv, esv;
    w2 = 16'hBEEF;
    for (int k = 0; k < 16; k++) begin
      receive2 = 1'b1; cs2 = 1'b0; miso2 = w2[15-k]; sif2.sample_ready = 1'b0;
      @(negedge clk);
      ebv = ((k + 1) % 8 == 0);
      ebd = (k >= 15) ? w2[7:0] : ((k >= 7) ? w2[15:8] : 8'h00);
      esv = (k == 15);
      checks++;
      if ({bv2, bd2, sif2.sample_valid} !== {ebv, ebd, esv}) begin
        failures++; $display("[TB] FAIL nb2_cycle%0d got=%h want=%h", k, {bv2, bd2, sif2.sample_valid}, {ebv, ebd, esv});
      end
    end
    checks++;
    if (sif2.sample_data !== w2) begin
      failures++; $display("[TB] FAIL nb2_sample got=%h want=%h", sif2.sample_data, w2);
    end
    receive2 = 1'b0; sif2.sample_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({sif2.sample_valid, fe2, ov2} !== 3'b000) begin
      failures++; $display("[TB] FAIL nb2_end got=%b want=000", {sif2.sample_valid, fe2, ov2});
    end
  endtask

  initial begin
    rst = 1'b1;
    receive = 1'b0; cs = 1'b1; miso = 1'b0; clear_overrun = 1'b0; sif.sample_ready = 1'b0;
    receive2 = 1'b0; cs2 = 1'b1; miso2 = 1'b0; clr2 = 1'b0; sif2.sample_ready = 1'b0;
    checks = 0; failures = 0;
    model_reset();
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_simultaneous();
    test_abort();
    test_async_reset();
    test_random_frames();
    test_param_two_bytes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_rx_assembler.md
# spi_rx_assembler

Receive-side stage of the SPI accelerometer master. It sits directly downstream of the MISO pin while the control FSM is in its RECEIVE phase. It deserialises MISO MSB-first into bytes and groups NUM_BYTES bytes into one sample word. It presents each sample to the consumer with a valid/ready handshake and flags overruns and aborted frames.

## Interface
Parameters:
- NUM_BYTES, 3: bytes per sample frame (XDATA, YDATA, ZDATA); legal range 1..8.

Ports:
- clk  input  1  serial clock (SCLK, 5 MHz); all logic on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- miso  input  1  serial data from slave, sampled on rising clk.
- cs  input  1  chip select, active low.
- receive  input  1  receive enable from control FSM.
- sample_ready  input  1  consumer accepts sample_data this cycle.
- clear_overrun  input  1  synchronous clear of the overrun flag.
- byte_data  output  8  last completed byte.
- byte_valid  output  1  one-cycle pulse: byte_data updated.
- sample_data  output  8*NUM_BYTES  assembled sample; first received byte in the MSBs.
- sample_valid  output  1  sample_data valid, held until accepted.
- overrun  output  1  sticky: a completed sample was dropped.
- frame_err  output  1  one-cycle pulse: frame aborted mid-way.

## Operation
- Enable condition: en = receive && !cs.
- States:
  - IDLE: counters at 0. The first edge with en high samples bit 0 and moves to SHIFT.
  - SHIFT: each edge with en high does shift <= {shift[6:0], miso} and bit_cnt +1.
- Byte completion: on the edge sampling bit 7 (bit_cnt == 7):
  - byte_data <= {shift[6:0], miso}; byte_valid high for the next cycle only.
  - bit_cnt wraps to 0 and byte_idx increments.
- Sample completion: on the edge completing byte_idx == NUM_BYTES-1:
  - byte_idx wraps to 0; the assembled word is offered to the output register.
  - The state stays SHIFT if en is still high. Back-to-back frames need no idle cycle.
- Output register:
  - If sample_valid is low, or sample_valid && sample_ready on the same edge: load the new word; sample_valid = 1.
  - Otherwise: drop the new word, keep the old word, set overrun.
- Handshake: the consumer completes a transfer on an edge with sample_valid && sample_ready. sample_valid then clears unless a new word loads on that same edge.
- clear_overrun clears overrun. If clear_overrun and a new overrun coincide, the set wins.
- Abort: en falls while in SHIFT with bit_cnt != 0 or byte_idx != 0:
  - The partial frame is discarded and the counters return to 0.
  - The state returns to IDLE; frame_err pulses one cycle.
  - sample_data and sample_valid are unaffected.
- A clean end (en falls with both counters at 0) returns to IDLE without frame_err.
- Width rules:
  - bit_cnt is 3 bits.
  - byte_idx is $clog2(NUM_BYTES) bits, minimum 1.
  - The assembly register is 8*NUM_BYTES bits. The byte with index i lands at bits [8*(NUM_BYTES-i)-1 -: 8].

## Timing
- Reset values: byte_data = 0, byte_valid = 0, sample_data = 0, sample_valid = 0, overrun = 0, frame_err = 0; state IDLE, counters 0.
- Byte latency: byte_valid is high in the cycle after the bit-7 edge, i.e. 8 cycles after the first bit edge of that byte.
- Sample latency: sample_valid rises on the cycle after the last bit edge of the frame (8*NUM_BYTES edges after the first bit).
- sample_valid and sample_data are stable while sample_valid is high and sample_ready is low.
- Reset asserted mid-frame: all state clears immediately (asynchronously). No frame_err is generated.
- frame_err and byte_valid never assert in the same cycle.

## Test plan
- Basic frame:
  - Stimulus: en high for 24 cycles; miso streams 0x12, 0x34, 0x56; sample_ready = 1.
  - Response: byte_valid pulses three times with 0x12, 0x34, 0x56. sample_data = 0x123456 with sample_valid high for one cycle. overrun = 0.
- Backpressure and overrun:
  - Stimulus: sample_ready = 0; two back-to-back frames 0xA1B2C3 then 0x010203.
  - Response: sample_data holds 0xA1B2C3 with overrun = 1. After sample_ready pulses, sample_valid drops. clear_overrun returns overrun to 0.
- Simultaneous accept and load:
  - Stimulus: sample_ready goes high on exactly the edge the second frame 0x0F0E0D completes.
  - Response: sample_data = 0x0F0E0D, sample_valid stays 1, overrun stays 0.
- Abort mid-byte:
  - Stimulus: cs rises after 13 bits.
  - Response: frame_err pulses once; there is no sample_valid. The next full frame 0x778899 assembles correctly.
- Async reset mid-frame:
  - Stimulus: rst pulses after 10 bits with sample_valid high.
  - Response: all outputs return to 0 immediately. The next frame assembles from bit 0.
- Parameter check:
  - Stimulus: NUM_BYTES = 2; stream 0xBEEF.
  - Response: sample_data = 0xBEEF, 16 bits wide, after 16 edges.
